// File: rtl/param_loop_pkg.sv
// rtl/param_loop_pkg.sv - shared state encoding and minimum-period helper for the parameter-loop sequencer
package param_loop_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COUNT    = 2'd1;
    localparam logic [1:0] ST_PULSE    = 2'd2;
    localparam logic [1:0] ST_WAIT_ACK = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        COUNT    = ST_COUNT,
        PULSE    = ST_PULSE,
        WAIT_ACK = ST_WAIT_ACK
    } loop_state_t;

    // Shortest period that leaves room for the full request pulse plus one
    // acknowledge cycle, so a new pulse never starts back-to-back with the last.
    function automatic int min_period(input int pulse_cycles);
        return pulse_cycles + 2;
    endfunction

endpackage

// File: rtl/param_loop_period_timer.sv
// rtl/param_loop_period_timer.sv - reloadable period down-counter with minimum-period clamp
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   run        : counter active; low holds the counter at 0
//   period     : requested period in clk cycles, sampled at every reload
//   expire     : high while the counter sits at 0 after having been loaded
module param_loop_period_timer #(
    parameter int PERIOD_W   = 24,
    parameter int MIN_PERIOD = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                expire
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

    logic [PERIOD_W-1:0] count_q;
    logic                running_q;
    logic [PERIOD_W-1:0] reload;

    always_comb begin
        reload = (period < MIN_P) ? (MIN_P - ONE_P) : (period - ONE_P);
    end

    // running_q separates the initial load (leaving IDLE) from a genuine
    // expiry, since both see the counter at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (!run) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (!running_q || (count_q == '0)) begin
            count_q   <= reload;
            running_q <= 1'b1;
        end else begin
            count_q   <= count_q - ONE_P;
        end
    end

    assign expire = running_q && (count_q == '0);

endmodule

// File: rtl/param_loop_tick_sequencer.sv
// rtl/param_loop_tick_sequencer.sv - periodic loop request generator with ack wait and overrun tracking
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   enable         : run request (level)
//   period_cycles  : loop period in clk cycles
//   loop_ack       : acknowledge from loop GPIO, rising edge = loop done
//   clear_overrun  : strobe clearing overrun and overrun_count
//   loop_req       : request pulse to loop GPIO
//   tick           : one-cycle strobe at every period expiry
//   busy           : high while pulsing or waiting for acknowledge
//   overrun        : sticky, a tick occurred while busy
//   overrun_count  : saturating count of overrun ticks
module param_loop_tick_sequencer
    import param_loop_pkg::*;
#(
    parameter int PERIOD_W     = 24,
    parameter int PULSE_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period_cycles,
    input  logic                loop_ack,
    input  logic                clear_overrun,
    output logic                loop_req,
    output logic                tick,
    output logic                busy,
    output logic                overrun,
    output logic [CNT_W-1:0]    overrun_count
);

    localparam int              MIN_PERIOD = min_period(PULSE_CYCLES);
    localparam int              PC_W       = $clog2(PULSE_CYCLES + 1);
    localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(PULSE_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    loop_state_t     state_q;
    loop_state_t     state_d;
    logic [PC_W-1:0] pulse_cnt_q;
    logic            ack_prev_q;
    logic            ack_rise;
    logic            expire;
    logic            run;
    logic            overrun_event;

    assign ack_rise = loop_ack && !ack_prev_q;
    assign run      = (state_d != IDLE);

    param_loop_period_timer #(
        .PERIOD_W   (PERIOD_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .period (period_cycles),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = COUNT;
            end
            COUNT: begin
                if (!enable)     state_d = IDLE;
                else if (expire) state_d = PULSE;
            end
            PULSE: begin
                // The pulse always runs to completion; enable only picks the exit.
                if (pulse_cnt_q == '0) state_d = enable ? WAIT_ACK : IDLE;
            end
            WAIT_ACK: begin
                // An ack landing on the expiry cycle closes the old loop first,
                // so the expiry starts a fresh pulse instead of counting an overrun.
                if (!enable)       state_d = IDLE;
                else if (ack_rise) state_d = expire ? PULSE : COUNT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overrun_event = 1'b0;
        if (expire) begin
            if (state_q == PULSE)                     overrun_event = 1'b1;
            else if (state_q == WAIT_ACK && !ack_rise) overrun_event = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pulse_cnt_q   <= '0;
            ack_prev_q    <= 1'b0;
            loop_req      <= 1'b0;
            tick          <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            state_q    <= state_d;
            ack_prev_q <= loop_ack;
            tick       <= expire;
            loop_req   <= (state_d == PULSE);
            busy       <= (state_d == PULSE) || (state_d == WAIT_ACK);

            if (state_d == PULSE && state_q != PULSE) begin
                pulse_cnt_q <= PULSE_LAST;
            end else if (state_q == PULSE && pulse_cnt_q != '0) begin
                pulse_cnt_q <= pulse_cnt_q - PC_ONE;
            end

            // A new overrun wins over a simultaneous clear and restarts the count at 1.
            if (overrun_event) begin
                overrun <= 1'b1;
                if (clear_overrun) begin
                    overrun_count <= CNT_ONE;
                end else if (overrun_count != '1) begin
                    overrun_count <= overrun_count + CNT_ONE;
                end
            end else if (clear_overrun) begin
                overrun       <= 1'b0;
                overrun_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_param_loop_tick_sequencer.sv
// tb/tb_param_loop_tick_sequencer.sv - directed self-checking bench for param_loop_tick_sequencer
module tb_param_loop_tick_sequencer;

    localparam int PERIOD_W     = 24;
    localparam int PULSE_CYCLES = 4;
    localparam int CNT_W        = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [PERIOD_W-1:0] period_cycles;
    logic                loop_ack;
    logic                clear_overrun;
    logic                loop_req;
    logic                tick;
    logic                busy;
    logic                overrun;
    logic [CNT_W-1:0]    overrun_count;

    param_loop_tick_sequencer #(
        .PERIOD_W     (PERIOD_W),
        .PULSE_CYCLES (PULSE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .period_cycles (period_cycles),
        .loop_ack      (loop_ack),
        .clear_overrun (clear_overrun),
        .loop_req      (loop_req),
        .tick          (tick),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int rel;
    int tick_cnt, first_tick, last_tick, space_min, space_max;
    int pulse_cnt, rise_with_tick, req_start, width_min, width_max;
    int busy_low;
    bit prev_req;
    bit ack_auto;
    int ack_delay;
    int ack_cd;
    bit seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        rel = 0;
        tick_cnt = 0; first_tick = -1; last_tick = -1; space_min = 1000; space_max = 0;
        pulse_cnt = 0; rise_with_tick = 0; req_start = 0; width_min = 1000; width_max = 0;
        busy_low = 0;
    endtask

    // One clock: sample #1 after the edge, update statistics, drive the ack responder.
    task automatic step();
        @(posedge clk);
        #1;
        rel++;
        if (tick) begin
            tick_cnt++;
            if (last_tick >= 0) begin
                if (rel - last_tick < space_min) space_min = rel - last_tick;
                if (rel - last_tick > space_max) space_max = rel - last_tick;
            end
            if (first_tick < 0) first_tick = rel;
            last_tick = rel;
        end
        if (loop_req && !prev_req) begin
            pulse_cnt++;
            req_start = rel;
            if (tick) rise_with_tick++;
        end
        if (!loop_req && prev_req) begin
            if (rel - req_start < width_min) width_min = rel - req_start;
            if (rel - req_start > width_max) width_max = rel - req_start;
        end
        if (first_tick >= 0 && !busy) busy_low++;
        if (loop_ack) loop_ack = 1'b0;
        if (ack_auto && prev_req && !loop_req) ack_cd = ack_delay;
        if (ack_cd == 0) begin
            loop_ack = 1'b1;
            ack_cd   = -1;
        end else if (ack_cd > 0) begin
            ack_cd--;
        end
        prev_req = loop_req;
    endtask

    task automatic do_reset();
        enable = 1'b0; loop_ack = 1'b0; clear_overrun = 1'b0;
        ack_auto = 1'b0; ack_cd = -1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_req(input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            step();
            if (loop_req) found = 1'b1;
        end
    endtask

    task automatic wait_tick(input int max_cycles, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            step();
            if (tick) found = 1'b1;
        end
    endtask

    initial begin
        prev_req = 1'b0; ack_auto = 1'b0; ack_delay = 0; ack_cd = -1;
        period_cycles = '0;
        clear_stats();
        reset = 1'b1; enable = 1'b0; loop_ack = 1'b0; clear_overrun = 1'b0;
        step(); step();
        check_eq("rst_loop_req", 32'(loop_req), 0);
        check_eq("rst_tick", 32'(tick), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_overrun", 32'(overrun), 0);
        check_eq("rst_overrun_count", 32'(overrun_count), 0);

        // 1: period 20, ack 3 cycles after loop_req falls
        do_reset();
        period_cycles = 24'd20; ack_auto = 1'b1; ack_delay = 2;
        clear_stats(); enable = 1'b1;
        repeat (61) step();
        check_eq("t1_ticks", tick_cnt, 3);
        check_eq("t1_first_tick", first_tick, 21);
        check_eq("t1_space_min", space_min, 20);
        check_eq("t1_space_max", space_max, 20);
        check_eq("t1_pulses", pulse_cnt, 3);
        check_eq("t1_req_with_tick", rise_with_tick, 3);
        check_eq("t1_width_min", width_min, 4);
        check_eq("t1_width_max", width_max, 4);
        check_eq("t1_overrun", 32'(overrun), 0);

        // 2: no ack -> two overruns, one pulse
        do_reset();
        period_cycles = 24'd20;
        clear_stats(); enable = 1'b1;
        repeat (61) step();
        check_eq("t2_ticks", tick_cnt, 3);
        check_eq("t2_first_tick", first_tick, 21);
        check_eq("t2_pulses", pulse_cnt, 1);
        check_eq("t2_overrun", 32'(overrun), 1);
        check_eq("t2_overrun_count", 32'(overrun_count), 2);
        check_eq("t2_busy", 32'(busy), 1);

        // 3: period 3 clamps to 6, prompt ack
        do_reset();
        period_cycles = 24'd3; ack_auto = 1'b1; ack_delay = 0;
        clear_stats(); enable = 1'b1;
        repeat (37) step();
        check_eq("t3_ticks", tick_cnt, 6);
        check_eq("t3_first_tick", first_tick, 7);
        check_eq("t3_space_min", space_min, 6);
        check_eq("t3_space_max", space_max, 6);
        check_eq("t3_pulses", pulse_cnt, 6);
        check_eq("t3_width_max", width_max, 4);
        check_eq("t3_busy_low", busy_low, 5);
        check_eq("t3_overrun_count", 32'(overrun_count), 0);

        // 4: ack rising edge on the expiry cycle
        do_reset();
        period_cycles = 24'd3; ack_auto = 1'b1; ack_delay = 1;
        clear_stats(); enable = 1'b1;
        repeat (37) step();
        check_eq("t4_ticks", tick_cnt, 6);
        check_eq("t4_pulses", pulse_cnt, 6);
        check_eq("t4_req_with_tick", rise_with_tick, 6);
        check_eq("t4_busy_low", busy_low, 0);
        check_eq("t4_overrun", 32'(overrun), 0);
        check_eq("t4_overrun_count", 32'(overrun_count), 0);

        // 5: enable dropped during PULSE
        do_reset();
        period_cycles = 24'd20; ack_auto = 1'b1; ack_delay = 2;
        clear_stats(); enable = 1'b1;
        wait_req(40, seen);
        check_eq("t5_req_seen", 32'(seen), 1);
        step();
        enable = 1'b0;
        repeat (40) step();
        check_eq("t5_pulses", pulse_cnt, 1);
        check_eq("t5_width_min", width_min, 4);
        check_eq("t5_width_max", width_max, 4);
        check_eq("t5_ticks", tick_cnt, 1);
        check_eq("t5_busy", 32'(busy), 0);
        check_eq("t5_loop_req", 32'(loop_req), 0);

        // 6: overrun_count saturation and clear/overrun collision
        do_reset();
        period_cycles = 24'd3;
        clear_stats(); enable = 1'b1;
        repeat (1700) step();
        check_eq("t6_sat_count", 32'(overrun_count), 255);
        check_eq("t6_sat_overrun", 32'(overrun), 1);
        wait_tick(12, seen);
        check_eq("t6_tick_seen", 32'(seen), 1);
        check_eq("t6_still_sat", 32'(overrun_count), 255);
        repeat (5) step();
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check_eq("t6_clr_tick", 32'(tick), 1);
        check_eq("t6_clr_overrun", 32'(overrun), 1);
        check_eq("t6_clr_count", 32'(overrun_count), 1);
        step(); step();
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check_eq("t6_plain_clr_overrun", 32'(overrun), 0);
        check_eq("t6_plain_clr_count", 32'(overrun_count), 0);

        // 7: reset while loop_req is high
        do_reset();
        period_cycles = 24'd20;
        clear_stats(); enable = 1'b1;
        wait_req(40, seen);
        check_eq("t7_req_seen", 32'(seen), 1);
        reset = 1'b1;
        step();
        check_eq("t7_loop_req", 32'(loop_req), 0);
        check_eq("t7_busy", 32'(busy), 0);
        check_eq("t7_tick", 32'(tick), 0);
        reset = 1'b0; enable = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
